// File: rtl/eth_rx.sv
// eth_rx: RMII receive engine.
// Samples RXD/CRS_DV on the 50 MHz reference clock, strips preamble and SFD,
// rebuilds bytes LSB-first, streams them into an external frame RAM and
// checks the Ethernet FCS. A finished frame is offered on a valid/ack
// handshake; while the consumer owns the RAM, new frames are dropped.
module eth_rx #(
   parameter logic [10:0] PAKET_MAX_SIZE = 11'd1500,
   parameter logic [4:0]  PREAMBLE_MIN   = 5'd8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [1:0]  i_eth_data,
   input  logic        i_eth_crs_dv,
   output logic [7:0]  o_ram_data,
   output logic [10:0] o_ram_adr,
   output logic        o_ram_we,
   output logic        o_rx_valid,
   output logic [10:0] o_rx_size,
   output logic        o_rx_crc_ok,
   input  logic        i_rx_ack,
   output logic        o_rx_err,
   output logic        o_rx_drop
);

   localparam logic [2:0] WAIT_IDLE = 3'd0;
   localparam logic [2:0] IDLE      = 3'd1;
   localparam logic [2:0] PREAMBLE  = 3'd2;
   localparam logic [2:0] DATA      = 3'd3;
   localparam logic [2:0] HOLD      = 3'd4;

   // Bytes beyond this count are not stored (payload plus 4 FCS bytes).
   localparam logic [10:0] BYTE_LIMIT  = PAKET_MAX_SIZE + 11'd4;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   // Reset synchronizer: asserts at once, releases on a clock edge.
   logic rst_meta;
   logic rst_sync;

   // Registered pin samples; the FSM only ever looks at these.
   logic [1:0] d;
   logic       dv;
   logic       dv_prev;

   // Receive state.
   logic [2:0]  state, state_n;
   logic [4:0]  pre_cnt, pre_cnt_n;
   logic [1:0]  phase, phase_n;
   logic [10:0] byte_cnt, byte_cnt_n;
   logic [5:0]  shift, shift_n;
   logic [31:0] crc, crc_n;

   // Events produced by the FSM in the cycle they are decided.
   logic [7:0]  byte_c;
   logic        we_c;
   logic [7:0]  data_c;
   logic [10:0] adr_c;
   logic        err_c;
   logic        drop_c;
   logic        valid_c;
   logic [10:0] size_c;
   logic        crc_ok_c;

   // Event pipeline stage between the FSM and the output registers.
   logic        we_q;
   logic [7:0]  data_q;
   logic [10:0] adr_q;
   logic        err_q;
   logic        drop_q;
   logic        valid_q;
   logic [10:0] size_q;
   logic        crc_ok_q;

   logic        ack_taken;

   // Reflected CRC-32 over one byte, least significant bit first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i])
            r = (r >> 1) ^ CRC_POLY;
         else
            r = r >> 1;
      end
      return r;
   endfunction

   // Synchronize reset release so internal logic leaves reset cleanly.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   // Input register stage; runs on the raw reset so it already tracks the
   // line while the internal reset is still releasing.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         d  <= 2'b00;
         dv <= 1'b0;
      end else begin
         d  <= i_eth_data;
         dv <= i_eth_crs_dv;
      end
   end

   // The consumer's ack only counts while a result is actually offered.
   assign ack_taken = o_rx_valid && i_rx_ack;

   // The completed byte when the current dibit is the fourth one.
   assign byte_c = {d, shift};

   // Receive FSM: preamble/SFD detection, byte assembly, CRC and frame end.
   always_comb begin
      state_n    = state;
      pre_cnt_n  = pre_cnt;
      phase_n    = phase;
      byte_cnt_n = byte_cnt;
      shift_n    = shift;
      crc_n      = crc;
      we_c       = 1'b0;
      data_c     = byte_c;
      adr_c      = byte_cnt;
      err_c      = 1'b0;
      drop_c     = 1'b0;
      valid_c    = 1'b0;
      size_c     = byte_cnt - 11'd4;
      crc_ok_c   = (crc == CRC_RESIDUE);

      case (state)
         WAIT_IDLE: begin
            if (!dv)
               state_n = IDLE;
         end

         IDLE: begin
            if (dv) begin
               if (d == 2'b01) begin
                  state_n   = PREAMBLE;
                  pre_cnt_n = 5'd1;
               end else if (d != 2'b00) begin
                  err_c   = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end
         end

         PREAMBLE: begin
            if (!dv) begin
               err_c   = 1'b1;
               state_n = WAIT_IDLE;
            end else if (d == 2'b01) begin
               if (pre_cnt != 5'd31)
                  pre_cnt_n = pre_cnt + 5'd1;
            end else if ((d == 2'b11) && (pre_cnt >= PREAMBLE_MIN)) begin
               state_n    = DATA;
               byte_cnt_n = 11'd0;
               phase_n    = 2'd0;
               crc_n      = CRC_INIT;
            end else begin
               err_c   = 1'b1;
               state_n = WAIT_IDLE;
            end
         end

         DATA: begin
            if (dv) begin
               shift_n = {d, shift[5:2]};
               phase_n = phase + 2'd1;
               if (phase == 2'd3) begin
                  if (byte_cnt < BYTE_LIMIT) begin
                     we_c  = 1'b1;
                     crc_n = crc_byte(crc, byte_c);
                  end
                  if (byte_cnt != 11'h7FF)
                     byte_cnt_n = byte_cnt + 11'd1;
               end
            end else begin
               if ((phase != 2'd0) || (byte_cnt < 11'd5) || (byte_cnt > BYTE_LIMIT)) begin
                  err_c   = 1'b1;
                  state_n = IDLE;
               end else begin
                  valid_c = 1'b1;
                  state_n = HOLD;
               end
            end
         end

         HOLD: begin
            if (ack_taken)
               state_n = dv ? WAIT_IDLE : IDLE;
            else if (dv && !dv_prev)
               drop_c = 1'b1;
         end

         default: begin
            state_n = WAIT_IDLE;
         end
      endcase
   end

   // FSM state and datapath registers.
   always_ff @(posedge i_clk or negedge rst_sync) begin
      if (!rst_sync) begin
         state    <= WAIT_IDLE;
         pre_cnt  <= 5'd0;
         phase    <= 2'd0;
         byte_cnt <= 11'd0;
         shift    <= 6'd0;
         crc      <= CRC_INIT;
         dv_prev  <= 1'b0;
      end else begin
         state    <= state_n;
         pre_cnt  <= pre_cnt_n;
         phase    <= phase_n;
         byte_cnt <= byte_cnt_n;
         shift    <= shift_n;
         crc      <= crc_n;
         dv_prev  <= dv;
      end
   end

   // Event stage: holds the FSM decisions for one cycle before the outputs.
   always_ff @(posedge i_clk or negedge rst_sync) begin
      if (!rst_sync) begin
         we_q     <= 1'b0;
         data_q   <= 8'd0;
         adr_q    <= 11'd0;
         err_q    <= 1'b0;
         drop_q   <= 1'b0;
         valid_q  <= 1'b0;
         size_q   <= 11'd0;
         crc_ok_q <= 1'b0;
      end else begin
         we_q     <= we_c;
         data_q   <= data_c;
         adr_q    <= adr_c;
         err_q    <= err_c;
         drop_q   <= drop_c;
         valid_q  <= valid_c;
         size_q   <= size_c;
         crc_ok_q <= crc_ok_c;
      end
   end

   // RAM write port; address and data keep the last written values.
   always_ff @(posedge i_clk or negedge rst_sync) begin
      if (!rst_sync) begin
         o_ram_we   <= 1'b0;
         o_ram_data <= 8'd0;
         o_ram_adr  <= 11'd0;
      end else begin
         o_ram_we <= we_q;
         if (we_q) begin
            o_ram_data <= data_q;
            o_ram_adr  <= adr_q;
         end
      end
   end

   // Frame result handshake; size and CRC flag freeze while valid is held.
   always_ff @(posedge i_clk or negedge rst_sync) begin
      if (!rst_sync) begin
         o_rx_valid  <= 1'b0;
         o_rx_size   <= 11'd0;
         o_rx_crc_ok <= 1'b0;
      end else begin
         if (ack_taken) begin
            o_rx_valid <= 1'b0;
         end else if (valid_q) begin
            o_rx_valid  <= 1'b1;
            o_rx_size   <= size_q;
            o_rx_crc_ok <= crc_ok_q;
         end
      end
   end

   // Single-cycle error and drop pulses.
   always_ff @(posedge i_clk or negedge rst_sync) begin
      if (!rst_sync) begin
         o_rx_err  <= 1'b0;
         o_rx_drop <= 1'b0;
      end else begin
         o_rx_err  <= err_q;
         o_rx_drop <= drop_q;
      end
   end

endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: randomized frame stimulus for eth_rx with a queue-based
// scoreboard. A frame-level model predicts RAM writes and frame events;
// a separate monitor compares everything the DUT presents.
`timescale 1ns/1ps
module tb_eth_rx;

   localparam int MAX_STORE = 1504;
   localparam int PRE_MIN   = 8;

   typedef struct {
      int adr;
      int data;
   } wr_t;

   // kind: 0 = frame valid, 1 = error pulse, 2 = drop pulse
   typedef struct {
      int kind;
      int size;
      int crc_ok;
   } ev_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  eth_data;
   logic        crs_dv;
   logic        rx_ack;
   logic [7:0]  ram_data;
   logic [10:0] ram_adr;
   logic        ram_we;
   logic        rx_valid;
   logic [10:0] rx_size;
   logic        rx_crc_ok;
   logic        rx_err;
   logic        rx_drop;

   wr_t        wr_q[$];
   ev_t        ev_q[$];
   logic [7:0] frame[$];

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int held_size = 0;
   int held_crc = 0;

   eth_rx dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_eth_data  (eth_data),
      .i_eth_crs_dv(crs_dv),
      .o_ram_data  (ram_data),
      .o_ram_adr   (ram_adr),
      .o_ram_we    (ram_we),
      .o_rx_valid  (rx_valid),
      .o_rx_size   (rx_size),
      .o_rx_crc_ok (rx_crc_ok),
      .i_rx_ack    (rx_ack),
      .o_rx_err    (rx_err),
      .o_rx_drop   (rx_drop)
   );

   // 50 MHz reference clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Cycle counter used for write spacing
   always @(posedge clk) cycle <= cycle + 1;

   // Safety net so the run always ends
   initial begin
      repeat (80000) @(posedge clk);
      $display("[TB] FAIL watchdog: run did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
      end
   endtask

   // Standard Ethernet FCS (with final inversion) over frame[0..n-1]
   function automatic logic [31:0] fcsOf(input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, frame[i]};
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Random payload followed by its FCS, transmitted least significant byte first
   task automatic buildFrame(input int plen);
      logic [31:0] f;
      frame.delete();
      for (int i = 0; i < plen; i++) frame.push_back(8'($urandom));
      f = fcsOf(plen);
      frame.push_back(f[7:0]);
      frame.push_back(f[15:8]);
      frame.push_back(f[23:16]);
      frame.push_back(f[31:24]);
   endtask

   // Frame-level reference: what the receiver must report for this frame
   task automatic modelFrame(input int pre, input int n, input int extra, input bit held);
      ev_t e;
      logic [31:0] rx_fcs;
      e.size = 0;
      e.crc_ok = 0;
      if (held) begin
         e.kind = 2;
         ev_q.push_back(e);
         return;
      end
      if (pre < PRE_MIN) begin
         e.kind = 1;
         ev_q.push_back(e);
         return;
      end
      for (int i = 0; i < n && i < MAX_STORE; i++) begin
         wr_t w;
         w.adr = i;
         w.data = int'(frame[i]);
         wr_q.push_back(w);
      end
      if (extra != 0 || n < 5 || n > MAX_STORE) begin
         e.kind = 1;
      end else begin
         rx_fcs = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
         e.kind = 0;
         e.size = n - 4;
         e.crc_ok = (fcsOf(n - 4) == rx_fcs) ? 1 : 0;
      end
      ev_q.push_back(e);
   endtask

   task automatic sendDibit(input logic [1:0] v, input logic en);
      @(negedge clk);
      eth_data = v;
      crs_dv = en;
   endtask

   // Drive preamble, SFD, the first n bytes of frame, extra dibits, then a gap
   task automatic applyStimulus(input int pre, input int n, input int extra);
      logic [7:0] b;
      for (int i = 0; i < pre; i++) sendDibit(2'b01, 1'b1);
      sendDibit(2'b11, 1'b1);
      for (int i = 0; i < n; i++) begin
         b = frame[i];
         for (int k = 0; k < 4; k++) sendDibit(b[2*k +: 2], 1'b1);
      end
      for (int i = 0; i < extra; i++) sendDibit(2'($urandom), 1'b1);
      repeat (12) sendDibit(2'b00, 1'b0);
   endtask

   task automatic waitValid();
      int n;
      n = 0;
      while (!rx_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput("valid_seen", int'(rx_valid), 1);
   endtask

   task automatic ackFrame();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      checkOutput("valid_cleared", int'(rx_valid), 0);
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_we", int'(ram_we), 0);
      checkOutput("rst_adr", int'(ram_adr), 0);
      checkOutput("rst_data", int'(ram_data), 0);
      checkOutput("rst_valid", int'(rx_valid), 0);
      checkOutput("rst_size", int'(rx_size), 0);
      checkOutput("rst_crc_ok", int'(rx_crc_ok), 0);
      checkOutput("rst_err", int'(rx_err), 0);
      checkOutput("rst_drop", int'(rx_drop), 0);
   endtask

   task automatic popEvent(input int kind);
      ev_t e;
      if (ev_q.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL unexpected_event: got kind %0d required none", kind);
         return;
      end
      e = ev_q.pop_front();
      checkOutput("event_kind", kind, e.kind);
      if (kind == 0 && e.kind == 0) begin
         checkOutput("rx_size", int'(rx_size), e.size);
         checkOutput("rx_crc_ok", int'(rx_crc_ok), e.crc_ok);
         held_size = e.size;
         held_crc = e.crc_ok;
      end
   endtask

   // Monitor: compares every write and event the DUT presents
   initial begin : monitor
      int prev_valid;
      int last_adr;
      int last_cyc;
      wr_t w;
      prev_valid = 0;
      last_adr = -1;
      last_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 0;
            last_adr = -1;
            continue;
         end
         if (ram_we) begin
            if (wr_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_write: got adr %0d data %0d required no write",
                        ram_adr, ram_data);
            end else begin
               w = wr_q.pop_front();
               checkOutput("wr_adr", int'(ram_adr), w.adr);
               checkOutput("wr_data", int'(ram_data), w.data);
            end
            if (last_adr >= 0 && int'(ram_adr) == last_adr + 1)
               checkOutput("wr_spacing", cycle - last_cyc, 4);
            last_adr = int'(ram_adr);
            last_cyc = cycle;
         end
         if (rx_err) popEvent(1);
         if (rx_drop) popEvent(2);
         if (rx_valid && prev_valid == 0) begin
            popEvent(0);
         end else if (rx_valid) begin
            checkOutput("held_size", int'(rx_size), held_size);
            checkOutput("held_crc_ok", int'(rx_crc_ok), held_crc);
         end
         prev_valid = int'(rx_valid);
      end
   end

   // Stimulus sequence
   initial begin : stim
      logic [7:0] b;
      int plen;
      int pre;
      rst_n = 1'b0;
      eth_data = 2'b00;
      crs_dv = 1'b0;
      rx_ack = 1'b0;
      repeat (4) @(negedge clk);
      checkResetOutputs();
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      $display("[TB] good 64-byte frame");
      buildFrame(60);
      modelFrame(31, 64, 0, 1'b0);
      applyStimulus(31, 64, 0);
      waitValid();
      ackFrame();

      $display("[TB] same frame with byte 10 corrupted");
      buildFrame(60);
      frame[10] = frame[10] ^ 8'h10;
      modelFrame(31, 64, 0, 1'b0);
      applyStimulus(31, 64, 0);
      waitValid();
      ackFrame();

      $display("[TB] frame ending 2 dibits into byte 20");
      buildFrame(60);
      modelFrame(31, 20, 2, 1'b0);
      applyStimulus(31, 20, 2);

      $display("[TB] short preambles 5 and 7");
      buildFrame(60);
      modelFrame(5, 64, 0, 1'b0);
      applyStimulus(5, 64, 0);
      buildFrame(20);
      modelFrame(7, 24, 0, 1'b0);
      applyStimulus(7, 24, 0);

      $display("[TB] runt and minimum frames");
      buildFrame(0);
      modelFrame(8, 4, 0, 1'b0);
      applyStimulus(8, 4, 0);
      buildFrame(1);
      modelFrame(8, 5, 0, 1'b0);
      applyStimulus(8, 5, 0);
      waitValid();
      ackFrame();

      $display("[TB] oversize 1510 and maximum 1504 byte frames");
      buildFrame(1506);
      modelFrame(20, 1510, 0, 1'b0);
      applyStimulus(20, 1510, 0);
      buildFrame(1500);
      modelFrame(20, 1504, 0, 1'b0);
      applyStimulus(20, 1504, 0);
      waitValid();
      ackFrame();

      $display("[TB] frame while buffer held");
      buildFrame(60);
      modelFrame(31, 64, 0, 1'b0);
      applyStimulus(31, 64, 0);
      waitValid();
      buildFrame(40);
      modelFrame(31, 44, 0, 1'b1);
      applyStimulus(31, 44, 0);
      ackFrame();
      buildFrame(30);
      modelFrame(12, 34, 0, 1'b0);
      applyStimulus(12, 34, 0);
      waitValid();
      ackFrame();

      $display("[TB] reset during byte 30");
      buildFrame(60);
      for (int i = 0; i < 30; i++) begin
         wr_t w;
         w.adr = i;
         w.data = int'(frame[i]);
         wr_q.push_back(w);
      end
      for (int i = 0; i < 31; i++) sendDibit(2'b01, 1'b1);
      sendDibit(2'b11, 1'b1);
      for (int i = 0; i < 30; i++) begin
         b = frame[i];
         for (int k = 0; k < 4; k++) sendDibit(b[2*k +: 2], 1'b1);
      end
      b = frame[30];
      for (int k = 0; k < 3; k++) sendDibit(b[2*k +: 2], 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      eth_data = b[7:6];
      #1;
      checkResetOutputs();
      b = frame[31];
      for (int k = 0; k < 4; k++) sendDibit(b[2*k +: 2], 1'b1);
      rst_n = 1'b1;
      for (int i = 32; i < 64; i++) begin
         b = frame[i];
         for (int k = 0; k < 4; k++) sendDibit(b[2*k +: 2], 1'b1);
      end
      repeat (12) sendDibit(2'b00, 1'b0);
      buildFrame(60);
      modelFrame(31, 64, 0, 1'b0);
      applyStimulus(31, 64, 0);
      waitValid();
      ackFrame();

      $display("[TB] random frames");
      for (int r = 0; r < 5; r++) begin
         plen = $urandom_range(1, 90);
         pre = $urandom_range(8, 31);
         buildFrame(plen);
         if ($urandom_range(0, 1) == 1) begin
            int idx;
            idx = $urandom_range(0, plen + 3);
            frame[idx] = frame[idx] ^ (8'd1 << $urandom_range(0, 7));
         end
         modelFrame(pre, plen + 4, 0, 1'b0);
         applyStimulus(pre, plen + 4, 0);
         waitValid();
         ackFrame();
      end

      repeat (20) @(negedge clk);
      checkOutput("writes_left", wr_q.size(), 0);
      checkOutput("events_left", ev_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eth_rx.md
# eth_rx

RMII receive engine, the counterpart of the 2-bit transmit path. Samples RXD[1:0]/CRS_DV on the 50 MHz reference clock, detects preamble and SFD, reassembles bytes LSB-first, writes them to an external frame RAM, and checks the Ethernet FCS. A completed frame is reported through a valid/ack handshake; the RAM is owned by the consumer until it acknowledges.

## Interface
Parameters:
- PAKET_MAX_SIZE, 11'd1500, maximum frame bytes excluding FCS; larger frames are errors.
- PREAMBLE_MIN, 5'd8, minimum count of 01 dibits before the SFD dibit 11.

Ports:
- i_clk  in  1  RMII reference clock, 50 MHz.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_eth_data  in  2  RMII RXD; first dibit of each byte is bits [1:0].
- i_eth_crs_dv  in  1  RMII carrier sense / data valid.
- o_ram_data  out  8  byte to write.
- o_ram_adr  out  11  write address, 0-based from first byte after SFD.
- o_ram_we  out  1  one-cycle write strobe.
- o_rx_valid  out  1  frame result available; held until i_rx_ack.
- o_rx_size  out  11  stored bytes minus 4 (FCS excluded); valid while o_rx_valid.
- o_rx_crc_ok  out  1  FCS check passed; valid while o_rx_valid.
- i_rx_ack  in  1  consumer releases buffer; sampled only while o_rx_valid=1.
- o_rx_err  out  1  one-cycle pulse: frame aborted (bad preamble, misalignment, runt, oversize).
- o_rx_drop  out  1  one-cycle pulse: frame ignored because buffer was held.

## Operation
- i_eth_data and i_eth_crs_dv pass through one input register stage; the FSM sees only registered values (d, dv).
- States: WAIT_IDLE, IDLE, PREAMBLE, DATA, HOLD.
- WAIT_IDLE: wait for dv=0, then IDLE. Entered after reset, after any error, and after ack if dv=1.
- IDLE: dv=1 and d=01 -> PREAMBLE with pre_cnt=1. dv=1 and d=00 -> stay. dv=1 with any other d -> o_rx_err, WAIT_IDLE.
- PREAMBLE: d=01 -> pre_cnt++ (saturate at 31). d=11 with pre_cnt>=PREAMBLE_MIN -> DATA, clear byte count, phase, and CRC (0xFFFFFFFF). d=11 early, d=00/10, or dv=0 -> o_rx_err, WAIT_IDLE.
- DATA, dv=1: dibit at phase k (0..3) goes to byte bits [2k+1:2k]; phase wraps 3->0. At phase 3 the byte is complete: if byte count < PAKET_MAX_SIZE+4, write it at address = byte count, assert o_ram_we, update CRC; byte count always increments (saturates at 2047).
- CRC: reflected CRC-32, polynomial 0xEDB88320, LSB first, init 0xFFFFFFFF, no final inversion, run over data and FCS bytes; pass when register = 0xDEBB20E3.
- DATA, dv=0 (end of frame), checked in order:
  - phase != 0 -> error.
  - byte count < 5 -> error.
  - byte count > PAKET_MAX_SIZE+4 -> error.
  - otherwise o_rx_size = count-4, o_rx_crc_ok latched, o_rx_valid=1, HOLD.
  - On error: o_rx_err pulse, IDLE.
- HOLD: i_rx_ack=1 -> o_rx_valid=0 next cycle; go IDLE if dv=0, else WAIT_IDLE. Any dv rising edge during HOLD -> one o_rx_drop pulse per frame, no RAM writes.
- CRC failure is not an error: the frame is reported with o_rx_crc_ok=0.

## Timing
- Reset: all outputs 0, o_ram_adr=0, state WAIT_IDLE, input registers 0. Async assert, sync deassert of internal use.
- Reset mid-frame: writes stop immediately. No valid/err is generated for the abandoned frame. The next frame is accepted only after dv=0 is seen.
- Write latency: the last dibit of a byte is sampled at pin edge E. o_ram_we, o_ram_data, and o_ram_adr are registered at E+2 and held for one cycle. Consecutive writes are 4 cycles apart.
- End latency: dv=0 is sampled at pin edge E. o_rx_valid (or o_rx_err) is registered at E+2.
- o_rx_size and o_rx_crc_ok are stable for the whole o_rx_valid interval.
- An ack and a new dv rising edge in the same cycle: the ack wins, the frame is not dropped, and the state goes to WAIT_IDLE (frame missed, no drop pulse).

## Test plan
- 31x01 + 11 + 64-byte frame with correct FCS -> 64 writes, addr 0..63, 4 cycles apart; o_rx_valid, size 60, crc_ok 1; data matches source.
- Same frame with byte 10 bit-flipped -> 64 writes; o_rx_valid, size 60, crc_ok 0; no o_rx_err.
- Frame ending 2 dibits into byte 20 -> o_rx_err pulse, o_rx_valid stays 0; 5x01 + 11 preamble -> o_rx_err, no writes.
- 1510-byte frame incl. FCS -> writes addr 0..1503 only; o_rx_err at end, no valid.
- Second frame sent while o_rx_valid held -> one o_rx_drop pulse, no writes, size/crc_ok unchanged. After i_rx_ack, a third frame is received normally.
- i_reset_n low during byte 30 -> all outputs 0 at once. Release with dv still high -> no writes until dv drops; the following frame is received correctly.
